// File: rtl/fifo_read_scheduler.sv
// Paces RX FIFO pops with a tick enable and packs byte pairs
// into 16-bit words written to SRAM at consecutive addresses.
module fifo_read_scheduler #(
  parameter int TICK_PERIOD = 10000,
  parameter int ADDR_W      = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len_words,
  input  logic              fifo_empty,
  input  logic [7:0]        fifo_dout,
  output logic              fifo_rd_en,
  output logic              sram_req,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_wdata,
  input  logic              sram_ack,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] word_count
);

  localparam int CW = (TICK_PERIOD > 2) ? $clog2(TICK_PERIOD) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    POP,
    CAPTURE,
    WRITE,
    FINISH
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]     cnt;
  logic              tick;
  logic              phase;
  logic              accept;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] count;
  logic [15:0]       wdata;

  assign tick   = (cnt == CW'(TICK_PERIOD - 1));
  assign accept = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    fifo_rd_en = 1'b0;
    sram_req   = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start)
          state_nx = (len_words == '0) ? FINISH : WAIT_TICK;
      end
      WAIT_TICK: begin
        // ticks with an empty FIFO are skipped, not remembered
        if (tick && !fifo_empty) state_nx = POP;
      end
      POP: begin
        fifo_rd_en = 1'b1;
        state_nx   = CAPTURE;
      end
      CAPTURE: begin
        state_nx = phase ? WRITE : WAIT_TICK;
      end
      WRITE: begin
        sram_req = 1'b1;
        if (sram_ack)
          state_nx = (count + 1'b1 == len) ? FINISH : WAIT_TICK;
      end
      FINISH: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
      addr  <= '0;
      len   <= '0;
      count <= '0;
      wdata <= '0;
    end else begin
      if (accept) begin
        cnt   <= '0;
        phase <= 1'b0;
        addr  <= base_addr;
        len   <= len_words;
        count <= '0;
      end else if (state != IDLE) begin
        cnt <= tick ? '0 : cnt + 1'b1;
      end
      if (state == CAPTURE) begin
        if (!phase) wdata[15:8] <= fifo_dout;
        else        wdata[7:0]  <= fifo_dout;
        phase <= ~phase;
      end
      if (state == WRITE && sram_ack) begin
        addr  <= addr + 1'b1;
        count <= count + 1'b1;
      end
    end
  end

  assign sram_addr  = addr;
  assign sram_wdata = wdata;
  assign word_count = count;

endmodule

// File: tb/tb_fifo_read_scheduler.sv
// Directed bench for fifo_read_scheduler with a FIFO model
// and an SRAM responder with programmable ack delay.
module tb_fifo_read_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [7:0]  len_words = '0;
  logic        fifo_empty;
  logic [7:0]  fifo_dout = '0;
  logic        fifo_rd_en;
  logic        sram_req;
  logic [7:0]  sram_addr;
  logic [15:0] sram_wdata;
  logic        sram_ack = 1'b0;
  logic        busy;
  logic        done;
  logic [7:0]  word_count;

  int checks = 0;
  int errors = 0;

  fifo_read_scheduler #(
    .TICK_PERIOD(4),
    .ADDR_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .len_words(len_words),
    .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en),
    .sram_req(sram_req),
    .sram_addr(sram_addr),
    .sram_wdata(sram_wdata),
    .sram_ack(sram_ack),
    .busy(busy),
    .done(done),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears the cycle after the pop strobe
  logic [7:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pops = 0;
  int bad_pop = 0;
  int pop_req = 0;
  int done_cnt = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      pops <= pops + 1;
      if (fifo_empty) begin
        bad_pop <= bad_pop + 1;
      end else begin
        fifo_dout <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1;
      end
      if (sram_req) pop_req <= pop_req + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  // SRAM responder: ack after ack_delay cycles of held request
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          nwr = 0;
  int          unstable = 0;
  logic        prev_req = 1'b0;
  logic [7:0]  held_a = '0;
  logic [15:0] held_d = '0;
  logic [7:0]  log_a [0:31];
  logic [15:0] log_d [0:31];

  always @(posedge clk) begin
    prev_req <= sram_req;
    if (sram_req && !prev_req) begin
      held_a <= sram_addr;
      held_d <= sram_wdata;
    end
    if (sram_req && prev_req &&
        (sram_addr !== held_a || sram_wdata !== held_d))
      unstable <= unstable + 1;
    if (sram_req && !sram_ack) begin
      if (wait_cnt >= ack_delay) begin
        sram_ack   <= 1'b1;
        log_a[nwr] <= sram_addr;
        log_d[nwr] <= sram_wdata;
        nwr        <= nwr + 1;
        wait_cnt   <= 0;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      sram_ack <= 1'b0;
      if (!sram_req) wait_cnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr++;
  endtask

  task automatic pulse_start(input logic [7:0] b, input logic [7:0] l);
    start     = 1'b1;
    base_addr = b;
    len_words = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  int w0, p0, d0, n;

  initial begin
    @(negedge clk);
    cyc(3);
    chk("rst_req", {31'd0, sram_req}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_rd", {31'd0, fifo_rd_en}, 0);
    chk("rst_wc", {24'd0, word_count}, 0);
    chk("rst_addr", {24'd0, sram_addr}, 0);
    chk("rst_wdata", {16'd0, sram_wdata}, 0);
    rst = 1'b0;
    cyc(2);

    // two words, ack one cycle after req, stray start mid-transfer
    w0 = nwr; d0 = done_cnt;
    push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
    pulse_start(8'h10, 8'd2);
    chk("n_busy", {31'd0, busy}, 1);
    cyc(3);
    pulse_start(8'h80, 8'd5);
    wait_idle("n_timeout", 200);
    chk("n_nwr", nwr - w0, 2);
    chk("n_a0", {24'd0, log_a[w0]}, 32'h10);
    chk("n_d0", {16'd0, log_d[w0]}, 32'hA1B2);
    chk("n_a1", {24'd0, log_a[w0+1]}, 32'h11);
    chk("n_d1", {16'd0, log_d[w0+1]}, 32'hC3D4);
    chk("n_done", done_cnt - d0, 1);
    chk("n_wc", {24'd0, word_count}, 2);
    cyc(5);
    chk("n_wc_hold", {24'd0, word_count}, 2);

    // empty FIFO for three ticks, then two bytes arrive
    w0 = nwr; p0 = pops;
    pulse_start(8'h20, 8'd1);
    cyc(14);
    chk("e_nopop", pops - p0, 0);
    push(8'h12); push(8'h34);
    n = 0;
    while (!sram_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("e_lat", n, 8);
    wait_idle("e_timeout", 100);
    chk("e_a", {24'd0, log_a[w0]}, 32'h20);
    chk("e_d", {16'd0, log_d[w0]}, 32'h1234);
    chk("e_wc", {24'd0, word_count}, 1);

    // slow ack: request held, ticks in WRITE dropped
    w0 = nwr; p0 = pops;
    ack_delay = 20;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    pulse_start(8'h30, 8'd2);
    wait_idle("s_timeout", 400);
    chk("s_nwr", nwr - w0, 2);
    chk("s_a0", {24'd0, log_a[w0]}, 32'h30);
    chk("s_d0", {16'd0, log_d[w0]}, 32'h1122);
    chk("s_a1", {24'd0, log_a[w0+1]}, 32'h31);
    chk("s_d1", {16'd0, log_d[w0+1]}, 32'h3344);
    chk("s_stable", unstable, 0);
    chk("s_poprq", pop_req, 0);
    chk("s_pops", pops - p0, 4);
    ack_delay = 0;

    // address wrap
    w0 = nwr;
    push(8'h5A); push(8'h6B); push(8'h7C); push(8'h8D);
    pulse_start(8'hFF, 8'd2);
    wait_idle("w_timeout", 200);
    chk("w_a0", {24'd0, log_a[w0]}, 32'hFF);
    chk("w_d0", {16'd0, log_d[w0]}, 32'h5A6B);
    chk("w_a1", {24'd0, log_a[w0+1]}, 32'h00);
    chk("w_d1", {16'd0, log_d[w0+1]}, 32'h7C8D);
    chk("w_wc", {24'd0, word_count}, 2);

    // zero length, with a start pulse while still busy
    w0 = nwr; p0 = pops; d0 = done_cnt;
    start = 1'b1; base_addr = 8'h60; len_words = 8'd0;
    @(negedge clk);
    chk("z_done", {31'd0, done}, 1);
    chk("z_busy", {31'd0, busy}, 1);
    len_words = 8'd3;
    @(negedge clk);
    start = 1'b0;
    chk("z_done_off", {31'd0, done}, 0);
    chk("z_idle", {31'd0, busy}, 0);
    cyc(20);
    chk("z_busy2", {31'd0, busy}, 0);
    chk("z_nwr", nwr - w0, 0);
    chk("z_pops", pops - p0, 0);
    chk("z_dcnt", done_cnt - d0, 1);
    chk("z_wc", {24'd0, word_count}, 0);

    // reset held three cycles while a write is pending
    ack_delay = 100;
    d0 = done_cnt;
    push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4);
    pulse_start(8'h40, 8'd2);
    n = 0;
    while (!sram_req && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("r_req_seen", {31'd0, sram_req}, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("r_req_drop", {31'd0, sram_req}, 0);
    cyc(2);
    chk("r_busy", {31'd0, busy}, 0);
    chk("r_done", {31'd0, done}, 0);
    chk("r_rd", {31'd0, fifo_rd_en}, 0);
    chk("r_wc", {24'd0, word_count}, 0);
    chk("r_dcnt", done_cnt - d0, 0);
    rst = 1'b0;
    ack_delay = 0;
    @(negedge clk);
    w0 = nwr;
    pulse_start(8'h50, 8'd1);
    wait_idle("r_timeout", 200);
    chk("r_a", {24'd0, log_a[w0]}, 32'h50);
    chk("r_d", {16'd0, log_d[w0]}, 32'hE3E4);
    chk("bad_pop", bad_pop, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
